// File: rtl/timer_scheduler_pkg.sv
// rtl/timer_scheduler_pkg.sv - shared state encoding and index helpers for timer_scheduler
package timer_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int N_REQ_DEFAULT = 4;
  localparam int IDX_W_DEFAULT = $clog2(N_REQ_DEFAULT);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// rtl/timer_scheduler_rr_arbiter.sv - combinational round-robin pick of the first set req at or after ptr
module rr_arbiter
  import timer_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'(wrap_idx(int'(ptr), k, N_REQ));
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - one shared down-counting delay timer, round-robin granted to N_REQ requesters
// Optional macro TIMER_SCHEDULER_ABORT_EN: owner dropping req in LOAD/RUN aborts without done.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       remaining
);

  localparam int IDX_W = idx_width(N_REQ);

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;

  logic [N_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             abort;
  logic [CNT_W-1:0] len_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = req_len[g*CNT_W +: CNT_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  assign ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef TIMER_SCHEDULER_ABORT_EN
  assign abort = ~req[owner_q];
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q <= ST_LOAD;
            owner_q <= arb_idx;
            grant_q <= arb_onehot;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD, ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
          end else if (state_q == ST_LOAD) begin
            cnt_q   <= len_arr[owner_q];
            state_q <= ST_RUN;
          end else if (enable) begin
            // Zero is terminal: finish instead of decrementing, so the count never wraps.
            if (cnt_q == '0) begin
              state_q <= ST_DONE;
              done_q  <= grant_q;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          ptr_q   <= ptr_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = cnt_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - scoreboard bench for timer_scheduler (directed vectors, done monitor)
module tb_timer_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_len = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  remaining;

  typedef struct {
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0;
  int   off;
  logic wrapped;
  logic [7:0] prev;

  timer_scheduler #(.N_REQ(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .req       (req),
    .req_len   (req_len),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requesters release req as soon as they observe their done pulse.
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      req = req & ~done;
    end
  endtask

  task automatic set_len(input int i, input logic [7:0] v);
    req_len[i*8 +: 8] = v;
  endtask

  task automatic push(input logic [3:0] m, input int c);
    exp_t x;
    x.mask = m;
    x.cyc  = c;
    sb.push_back(x);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done != 4'b0000) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got %b want none (cycle %0d)", done, cyc);
        end else begin
          e = sb.pop_front();
          check("done_mask", 32'(done), 32'(e.mask));
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    cycles(2);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_remaining", 32'(remaining), 0);
    reset_n = 1'b1;
    cycles(1);

    // single request, len 5
    set_len(1, 8'd5);
    req = 4'b0010;
    t0 = cyc;
    push(4'b0010, t0 + 8);
    for (int i = 1; i <= 8; i++) begin
      cycles(1);
      check("t1_grant", 32'(grant), 32'h2);
      if (i == 2) check("t1_remaining", 32'(remaining), 5);
    end
    cycles(1);
    check("t1_idle_grant", 32'(grant), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_sb_empty", sb.size(), 0);

    // all four from reset, lengths 0/1/2/3
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) set_len(i, 8'(i));
    req = 4'b1111;
    t0 = cyc;
    push(4'b0001, t0 + 3);
    push(4'b0010, t0 + 8);
    push(4'b0100, t0 + 14);
    push(4'b1000, t0 + 21);
    for (int i = 1; i <= 25; i++) begin
      cycles(1);
      case (i)
        1:  check("t2_grant0", 32'(grant), 32'h1);
        5:  check("t2_grant1", 32'(grant), 32'h2);
        10: check("t2_grant2", 32'(grant), 32'h4);
        16: check("t2_grant3", 32'(grant), 32'h8);
        default: ;
      endcase
    end
    check("t2_sb_empty", sb.size(), 0);

    // len 0 with enable low for three RUN cycles
    set_len(0, 8'd0);
    req = 4'b0001;
    t0 = cyc;
    push(4'b0001, t0 + 6);
    cycles(2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_remaining", 32'(remaining), 0);
      cycles(1);
    end
    enable = 1'b1;
    check("t3_remaining_last", 32'(remaining), 0);
    cycles(3);
    check("t3_sb_empty", sb.size(), 0);

    // max length 255
    set_len(1, 8'd255);
    req = 4'b0010;
    t0 = cyc;
    push(4'b0010, t0 + 258);
    wrapped = 1'b0;
    prev = 8'd0;
    for (int i = 1; i <= 260; i++) begin
      cycles(1);
      off = cyc - t0;
      if (off == 2) check("t4_remaining_start", 32'(remaining), 255);
      if (off > 2 && remaining > prev) wrapped = 1'b1;
      if (off == 257) check("t4_remaining_end", 32'(remaining), 0);
      prev = remaining;
    end
    check("t4_no_wrap", 32'(wrapped), 0);
    check("t4_sb_empty", sb.size(), 0);

    // reset mid-RUN: no done, pointer back to 0
    set_len(3, 8'd10);
    set_len(0, 8'd0);
    req = 4'b1000;
    t0 = cyc;
    cycles(5);
    check("t5_remaining_run", 32'(remaining), 7);
    reset_n = 1'b0;
    #1;
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_remaining", 32'(remaining), 0);
    check("t5_rst_done", 32'(done), 0);
    cycles(2);
    reset_n = 1'b1;
    req = 4'b1001;
    t0 = cyc;
    push(4'b0001, t0 + 3);
    push(4'b1000, t0 + 17);
    cycles(1);
    check("t5_grant_after_rst", 32'(grant), 32'h1);
    cycles(19);
    check("t5_sb_empty", sb.size(), 0);

    // requester 2 drops req mid-RUN, requester 3 waiting
    set_len(2, 8'd20);
    set_len(3, 8'd2);
    req = 4'b0100;
    t0 = cyc;
`ifdef TIMER_SCHEDULER_ABORT_EN
    push(4'b1000, t0 + 11);
`else
    push(4'b0100, t0 + 23);
    push(4'b1000, t0 + 29);
`endif
    cycles(5);
    req = 4'b1000;
    cycles(1);
`ifdef TIMER_SCHEDULER_ABORT_EN
    check("t6_abort_grant", 32'(grant), 0);
    cycles(1);
    check("t6_next_grant", 32'(grant), 32'h8);
    cycles(30);
`else
    check("t6_keep_grant", 32'(grant), 32'h4);
    cycles(31);
`endif
    check("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
